// File: rtl/ysyx_23060187_ifu.sv
// rtl/ysyx_23060187_ifu.sv - multi-cycle instruction fetch unit, optional perf counters via YSYX_23060187_IFU_PERF_EN
module ysyx_23060187_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] ifu_araddr,
    output logic        ifu_arvalid,
    input  logic        ifu_arready,
    input  logic [31:0] ifu_rdata,
    input  logic [1:0]  ifu_rresp,
    input  logic        ifu_rvalid,
    output logic        ifu_rready,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_fault,
    input  logic        wbu_valid,
    input  logic [31:0] wbu_next_pc,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_OUT,
        S_WAIT
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;

    // The bus only ever sees word addresses; the full pc is kept for decode.
    assign ifu_araddr = {pc[31:2], 2'b00};

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and state-decoded handshake outputs
    always_comb begin
        state_next  = state;
        ifu_arvalid = 1'b0;
        ifu_rready  = 1'b0;
        inst_valid  = 1'b0;
        unique case (state)
            S_IDLE: begin
                state_next = S_ADDR;
            end
            S_ADDR: begin
                ifu_arvalid = 1'b1;
                if (ifu_arready) state_next = S_DATA;
            end
            S_DATA: begin
                ifu_rready = 1'b1;
                if (ifu_rvalid) state_next = S_OUT;
            end
            S_OUT: begin
                inst_valid = 1'b1;
                if (inst_ready) state_next = S_WAIT;
            end
            S_WAIT: begin
                if (wbu_valid) state_next = S_ADDR;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // PC and fetched-instruction registers; captures happen only in their own state
    always_ff @(posedge clk) begin
        if (rst) begin
            pc         <= RESET_PC;
            inst       <= 32'h0;
            inst_pc    <= RESET_PC;
            inst_fault <= 1'b0;
        end else begin
            if (state == S_DATA && ifu_rvalid) begin
                inst       <= ifu_rdata;
                inst_pc    <= pc;
                inst_fault <= (ifu_rresp != 2'b00);
            end
            if (state == S_WAIT && wbu_valid) begin
                pc <= wbu_next_pc;
            end
        end
    end

`ifdef YSYX_23060187_IFU_PERF_EN
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;

    // Completed fetches and memory-wait cycles, both wrapping
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt <= 32'h0;
            stall_cnt <= 32'h0;
        end else begin
            if (state == S_DATA && ifu_rvalid) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
            if ((state == S_ADDR && !ifu_arready) || (state == S_DATA && !ifu_rvalid)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = fetch_cnt;
    assign perf_stall_cnt = stall_cnt;
`else
    assign perf_fetch_cnt = 32'h0;
    assign perf_stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_ysyx_23060187_ifu.sv
// tb/tb_ysyx_23060187_ifu.sv - scoreboard bench for the instruction fetch unit
module tb_ysyx_23060187_ifu;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    logic        clk;
    logic        rst;
    logic [31:0] ifu_araddr;
    logic        ifu_arvalid;
    logic        ifu_arready;
    logic [31:0] ifu_rdata;
    logic [1:0]  ifu_rresp;
    logic        ifu_rvalid;
    logic        ifu_rready;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_fault;
    logic        wbu_valid;
    logic [31:0] wbu_next_pc;
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;

    ysyx_23060187_ifu dut (
        .clk(clk), .rst(rst),
        .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
        .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
        .inst_fault(inst_fault), .wbu_valid(wbu_valid), .wbu_next_pc(wbu_next_pc),
        .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt)
    );

    typedef struct {
        logic [31:0] word;
        logic [31:0] pc;
        logic        fault;
    } exp_inst_t;

    int          checks = 0;
    int          fails = 0;
    int          inst_seen = 0;
    int          ar_wait = 0;
    int          r_wait = 0;
    int          ar_cnt = 0;
    int          r_cnt = 0;
    logic        force_rvalid = 1'b0;
    logic [31:0] addr_q[$];
    exp_inst_t   inst_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Memory responder: reacts to the DUT's state-decoded valids after each falling edge
    initial begin
        ifu_arready = 1'b0;
        ifu_rvalid  = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (ifu_arvalid) begin
                ifu_arready = (ar_cnt >= ar_wait);
                ar_cnt++;
            end else begin
                ifu_arready = 1'b0;
                ar_cnt = 0;
            end
            if (ifu_rready) begin
                ifu_rvalid = (r_cnt >= r_wait);
                r_cnt++;
            end else begin
                ifu_rvalid = force_rvalid;
                r_cnt = 0;
            end
        end
    end

    // Monitor: compares bus address and presented instructions against queued expectations
    initial begin
        exp_inst_t e;
        logic [31:0] a;
        forever begin
            @(negedge clk);
            #2;
            if (ifu_arvalid) begin
                if (addr_q.size() == 0) begin
                    check("unexpected_arvalid", 32'd1, 32'd0);
                end else begin
                    check("araddr", ifu_araddr, addr_q[0]);
                    if (ifu_arready) a = addr_q.pop_front();
                end
            end
            if (inst_valid && inst_ready) begin
                if (inst_q.size() == 0) begin
                    check("unexpected_inst", 32'd1, 32'd0);
                end else begin
                    e = inst_q.pop_front();
                    check("inst", inst, e.word);
                    check("inst_pc", inst_pc, e.pc);
                    check("inst_fault", {31'd0, inst_fault}, {31'd0, e.fault});
                end
                inst_seen++;
            end
        end
    end

    task automatic issue(input logic [31:0] addr, input logic [31:0] pc, input logic [31:0] data,
                         input logic [1:0] resp, input int arw, input int rw, input bit push_inst);
        exp_inst_t e;
        ar_wait   = arw;
        r_wait    = rw;
        ifu_rdata = data;
        ifu_rresp = resp;
        addr_q.push_back(addr);
        if (push_inst) begin
            e.word  = data;
            e.pc    = pc;
            e.fault = (resp != 2'b00);
            inst_q.push_back(e);
        end
    endtask

    task automatic commit(input logic [31:0] next_pc);
        wbu_valid   = 1'b1;
        wbu_next_pc = next_pc;
        @(negedge clk);
        wbu_valid   = 1'b0;
    endtask

    task automatic wait_inst_done(input int target);
        int n = 0;
        while (inst_seen < target && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (inst_seen < target) check("timeout_inst_done", 32'd1, 32'd0);
    endtask

    task automatic wait_inst_valid();
        int n = 0;
        while (!inst_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!inst_valid) check("timeout_inst_valid", 32'd1, 32'd0);
    endtask

    task automatic wait_rready();
        int n = 0;
        while (!ifu_rready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!ifu_rready) check("timeout_rready", 32'd1, 32'd0);
    endtask

    task automatic wait_arvalid();
        int n = 0;
        while (!ifu_arvalid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!ifu_arvalid) check("timeout_arvalid", 32'd1, 32'd0);
    endtask

    initial begin
        rst         = 1'b1;
        inst_ready  = 1'b1;
        wbu_valid   = 1'b0;
        wbu_next_pc = 32'h0;
        ifu_rdata   = 32'h0;
        ifu_rresp   = 2'b00;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_arvalid", {31'd0, ifu_arvalid}, 32'd0);
        check("rst_rready", {31'd0, ifu_rready}, 32'd0);
        check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        check("rst_inst", inst, 32'h0);
        check("rst_inst_pc", inst_pc, RESET_PC);
        check("rst_inst_fault", {31'd0, inst_fault}, 32'd0);
        check("rst_perf_fetch", perf_fetch_cnt, 32'd0);
        check("rst_perf_stall", perf_stall_cnt, 32'd0);

        // Slow memory: arready late by 3, rvalid late by 2
        issue(RESET_PC, RESET_PC, 32'h0000_0413, 2'b00, 3, 2, 1'b1);
        rst = 1'b0;
        check("idle_arvalid", {31'd0, ifu_arvalid}, 32'd0);
        @(negedge clk);
        check("first_arvalid", {31'd0, ifu_arvalid}, 32'd1);
        check("first_araddr", ifu_araddr, RESET_PC);
        wait_inst_done(1);
`ifdef YSYX_23060187_IFU_PERF_EN
        check("perf_stall", perf_stall_cnt, 32'd5);
        check("perf_fetch", perf_fetch_cnt, 32'd1);
`else
        check("perf_stall_off", perf_stall_cnt, 32'd0);
        check("perf_fetch_off", perf_fetch_cnt, 32'd0);
`endif

        // Zero-wait fetch with latency checks
        issue(32'h8000_0004, 32'h8000_0004, 32'h0010_0093, 2'b00, 0, 0, 1'b1);
        commit(32'h8000_0004);
        wait_arvalid();
        @(negedge clk);
        check("lat_rready_t1", {31'd0, ifu_rready}, 32'd1);
        check("lat_inst_valid_t1", {31'd0, inst_valid}, 32'd0);
        @(negedge clk);
        check("lat_inst_valid_t2", {31'd0, inst_valid}, 32'd1);
        wait_inst_done(2);
        issue(32'h8000_0008, 32'h8000_0008, 32'h1234_5678, 2'b00, 0, 0, 1'b1);
        inst_ready = 1'b0;
        commit(32'h8000_0008);
        check("lat_arvalid_t4", {31'd0, ifu_arvalid}, 32'd1);

        // Decode back-pressure for 4 cycles
        wait_inst_valid();
        for (int i = 0; i < 4; i++) begin
            check("hold_inst_valid", {31'd0, inst_valid}, 32'd1);
            check("hold_inst", inst, 32'h1234_5678);
            check("hold_inst_pc", inst_pc, 32'h8000_0008);
            check("hold_no_arvalid", {31'd0, ifu_arvalid}, 32'd0);
            @(negedge clk);
        end
        inst_ready = 1'b1;
        wait_inst_done(3);

        // Faulting response, then recovery from the supplied next pc
        issue(32'h8000_000C, 32'h8000_000C, 32'hFFFF_FFFF, 2'b10, 0, 0, 1'b1);
        commit(32'h8000_000C);
        wait_inst_done(4);
        issue(32'h8000_0100, 32'h8000_0100, 32'h0000_0013, 2'b00, 0, 2, 1'b1);
        commit(32'h8000_0100);

        // Early wbu_valid pulse during S_DATA is ignored
        wait_rready();
        wbu_valid   = 1'b1;
        wbu_next_pc = 32'h8000_0200;
        @(negedge clk);
        wbu_valid = 1'b0;
        wait_inst_done(5);
        issue(32'h8000_0020, 32'h8000_0022, 32'h0050_0593, 2'b00, 0, 0, 1'b1);
        commit(32'h8000_0022);
        wait_inst_done(6);

        // Reset while in S_DATA with a late rvalid
        issue(32'h8000_0030, 32'h8000_0030, 32'hAAAA_5555, 2'b00, 0, 5, 1'b0);
        commit(32'h8000_0030);
        wait_rready();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        issue(RESET_PC, RESET_PC, 32'h0000_0513, 2'b00, 0, 0, 1'b1);
        ifu_rdata    = 32'hDEAD_BEEF;
        force_rvalid = 1'b1;
        check("mid_rst_arvalid", {31'd0, ifu_arvalid}, 32'd0);
        check("mid_rst_rready", {31'd0, ifu_rready}, 32'd0);
        check("mid_rst_inst_pc", inst_pc, RESET_PC);
        @(negedge clk);
        force_rvalid = 1'b0;
        ifu_rdata    = 32'h0000_0513;
        check("mid_rst_inst_kept", inst, 32'h0);
        check("mid_rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        check("mid_rst_arvalid2", {31'd0, ifu_arvalid}, 32'd1);
        check("mid_rst_araddr", ifu_araddr, RESET_PC);
        wait_inst_done(7);

        check("addr_q_empty", addr_q.size(), 32'd0);
        check("inst_q_empty", inst_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

endmodule
